// File: rtl/serial_word_loader.sv
// Serial-to-parallel word loader: gathers WIDTH framed serial bits and hands the
// finished word to a downstream register with a single-cycle load strobe.
module serial_word_loader #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_sin_valid,
  input  logic             i_sin,
  output logic             o_ready,
  output logic             o_busy,
  output logic             o_load,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_err
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_LOAD  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_shreg;
  logic [WIDTH-1:0]   r_dout;
  logic               r_err;
  logic [WIDTH-1:0]   w_shreg_nxt;
  logic               w_last;

  // Bit order selects which end of the shift register the new bit enters.
  generate
    if (MSB_FIRST) begin : g_msb_first
      assign w_shreg_nxt = {r_shreg[WIDTH-2:0], i_sin};
    end else begin : g_lsb_first
      assign w_shreg_nxt = {i_sin, r_shreg[WIDTH-1:1]};
    end
  endgenerate

  assign w_last = (r_cnt == CNT_LAST);

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode; start always (re)enters SHIFT.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_start) w_state_nxt = S_SHIFT;
        else         w_state_nxt = S_IDLE;
      end
      S_SHIFT: begin
        if (i_start)                  w_state_nxt = S_SHIFT;
        else if (i_sin_valid && w_last) w_state_nxt = S_LOAD;
        else                          w_state_nxt = S_SHIFT;
      end
      S_LOAD: begin
        if (i_start) w_state_nxt = S_SHIFT;
        else         w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath: counter, shift register, output word and sticky error flag.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt   <= '0;
      r_shreg <= '0;
      r_dout  <= '0;
      r_err   <= 1'b0;
    end else if (i_start) begin
      r_cnt   <= '0;
      r_shreg <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_SHIFT: begin
          if (i_sin_valid) begin
            r_shreg <= w_shreg_nxt;
            if (w_last) begin
              r_dout <= w_shreg_nxt;
              r_cnt  <= '0;
            end else begin
              r_cnt  <= r_cnt + CNT_W'(1);
            end
          end
        end
        S_IDLE, S_LOAD: begin
          if (i_sin_valid) r_err <= 1'b1;
        end
        default: begin
          r_cnt   <= '0;
          r_shreg <= '0;
        end
      endcase
    end
  end

  // Status outputs are pure state decodes so they carry no input-to-output path.
  always_comb begin
    o_ready = 1'b0;
    o_busy  = 1'b0;
    o_load  = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_ready = 1'b0;
        o_busy  = 1'b0;
        o_load  = 1'b0;
      end
      S_SHIFT: begin
        o_ready = 1'b1;
        o_busy  = 1'b1;
        o_load  = 1'b0;
      end
      S_LOAD: begin
        o_ready = 1'b0;
        o_busy  = 1'b1;
        o_load  = 1'b1;
      end
      default: begin
        o_ready = 1'b0;
        o_busy  = 1'b0;
        o_load  = 1'b0;
      end
    endcase
  end

  assign o_dout = r_dout;
  assign o_err  = r_err;

endmodule

// File: tb/tb_serial_word_loader.sv
// Directed bench for serial_word_loader: LSB-first and MSB-first instances share
// one stimulus stream; a behavioural model feeds per-instance scoreboards.
module tb_serial_word_loader;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic         sin_valid = 1'b0;
  logic         sin = 1'b0;
  logic         ready0, busy0, load0, err0;
  logic         ready1, busy1, load1, err1;
  logic [W-1:0] dout0, dout1;

  int n_pass  = 0;
  int n_total = 0;

  // model state: 0 idle, 1 shift, 2 load
  int           m_state = 0;
  int           m_cnt   = 0;
  logic         m_err   = 1'b0;
  logic [W-1:0] m_w0    = '0;
  logic [W-1:0] m_w1    = '0;
  logic [W-1:0] m_d0    = '0;
  logic [W-1:0] m_d1    = '0;
  logic [W-1:0] q0[$];
  logic [W-1:0] q1[$];

  always #5 clk = ~clk;

  serial_word_loader #(.WIDTH(W), .MSB_FIRST(1'b0)) dut0 (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_sin_valid(sin_valid), .i_sin(sin),
    .o_ready(ready0), .o_busy(busy0), .o_load(load0), .o_dout(dout0), .o_err(err0)
  );

  serial_word_loader #(.WIDTH(W), .MSB_FIRST(1'b1)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_sin_valid(sin_valid), .i_sin(sin),
    .o_ready(ready1), .o_busy(busy1), .o_load(load1), .o_dout(dout1), .o_err(err1)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // One clock: drive inputs, advance the model across the edge, then check.
  task automatic cyc(input logic s, input logic v, input logic b, input logic r);
    logic [W-1:0] w;
    start = s; sin_valid = v; sin = b; rst = r;
    @(posedge clk);
    if (r) begin
      m_state = 0; m_cnt = 0; m_err = 1'b0; m_d0 = '0; m_d1 = '0;
      q0.delete(); q1.delete();
    end else if (s) begin
      m_state = 1; m_cnt = 0; m_err = 1'b0; m_w0 = '0; m_w1 = '0;
    end else begin
      case (m_state)
        1: begin
          if (v) begin
            m_w0[m_cnt] = b;
            m_w1[W-1-m_cnt] = b;
            if (m_cnt == W - 1) begin
              q0.push_back(m_w0); q1.push_back(m_w1);
              m_d0 = m_w0; m_d1 = m_w1;
              m_state = 2; m_cnt = 0;
            end else begin
              m_cnt++;
            end
          end
        end
        2: begin
          if (v) m_err = 1'b1;
          m_state = 0;
        end
        default: begin
          if (v) m_err = 1'b1;
        end
      endcase
    end
    #1;
    chk("load0", 16'(load0), 16'(m_state == 2));
    chk("load1", 16'(load1), 16'(m_state == 2));
    chk("ready0", 16'(ready0), 16'(m_state == 1));
    chk("busy0", 16'(busy0), 16'(m_state != 0));
    chk("busy1", 16'(busy1), 16'(m_state != 0));
    chk("err0", 16'(err0), 16'(m_err));
    chk("err1", 16'(err1), 16'(m_err));
    chk("dout0_hold", 16'(dout0), 16'(m_d0));
    chk("dout1_hold", 16'(dout1), 16'(m_d1));
    if (load0) begin
      if (q0.size() == 0) chk("sb0_unexpected_load", 16'd1, 16'd0);
      else begin w = q0.pop_front(); chk("sb0_word", 16'(dout0), 16'(w)); end
    end
    if (load1) begin
      if (q1.size() == 0) chk("sb1_unexpected_load", 16'd1, 16'd0);
      else begin w = q1.pop_front(); chk("sb1_word", 16'(dout1), 16'(w)); end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic bit_in(input logic b);
    cyc(1'b0, 1'b1, b, 1'b0);
  endtask

  initial begin
    // reset state
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk("rst_dout0", 16'(dout0), 16'h0);
    chk("rst_busy0", 16'(busy0), 16'h0);

    // 1/2: bits 1,0,1,1 with gaps
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    bit_in(1'b1); idle(2);
    bit_in(1'b0); idle(1);
    bit_in(1'b1); idle(3);
    bit_in(1'b1);
    chk("t1_load0", 16'(load0), 16'h1);
    idle(2);
    chk("t1_dout0", 16'(dout0), 16'hD);
    chk("t2_dout1", 16'(dout1), 16'hB);
    chk("t1_err", 16'(err0), 16'h0);

    // 3: restart mid-frame
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    bit_in(1'b1); bit_in(1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    bit_in(1'b1); bit_in(1'b1); bit_in(1'b1); bit_in(1'b1);
    idle(2);
    chk("t3_dout0", 16'(dout0), 16'hF);
    chk("t3_dout1", 16'(dout1), 16'hF);

    // 4: stray bit in IDLE sets sticky err; start clears it
    bit_in(1'b1);
    idle(3);
    chk("t4_err_sticky", 16'(err0), 16'h1);
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    chk("t4_err_clr", 16'(err0), 16'h0);

    // 5: reset mid-frame, then a fresh frame 0,0,0,1
    bit_in(1'b1); bit_in(1'b1); bit_in(1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk("t5_rst_dout0", 16'(dout0), 16'h0);
    chk("t5_rst_ready", 16'(ready0), 16'h0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    bit_in(1'b0); bit_in(1'b0); bit_in(1'b0); bit_in(1'b1);
    idle(1);
    chk("t5_dout0", 16'(dout0), 16'h8);
    chk("t5_dout1", 16'(dout1), 16'h1);

    // 6: start during LOAD gives back-to-back frames
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    bit_in(1'b1); bit_in(1'b0); bit_in(1'b0); bit_in(1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk("t6_busy_kept", 16'(busy0), 16'h1);
    bit_in(1'b0); bit_in(1'b1); bit_in(1'b1); bit_in(1'b0);
    chk("t6_dout0", 16'(dout0), 16'h6);
    chk("t6_dout1", 16'(dout1), 16'h6);

    // stray bit during LOAD sets err
    bit_in(1'b1);
    chk("t7_err_load", 16'(err0), 16'h1);
    idle(2);

    chk("sb0_drained", 16'(q0.size()), 16'h0);
    chk("sb1_drained", 16'(q1.size()), 16'h0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
